// File: rtl/pattern_scan_pkg.sv
// rtl/pattern_scan_pkg.sv - shared encodings and detector transition function
// Contents:
//   det_state_t  : serial 001/110 detector states
//   ctrl_state_t : word controller states
//   det_next()   : detector next-state function (x is the incoming bit)
package pattern_scan_pkg;

  typedef enum logic [2:0] {
    S0    = 3'b000,
    START = 3'b001,
    S00   = 3'b010,
    S001  = 3'b011,
    S1    = 3'b100,
    S11   = 3'b101,
    S110  = 3'b110
  } det_state_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ctrl_state_t;

  function automatic det_state_t det_next(input det_state_t s, input logic x);
    det_state_t n;
    n = START;
    case (s)
      START: n = x ? S1   : S0;
      S0:    n = x ? S1   : S00;
      S00:   n = x ? S001 : S00;
      S001:  n = x ? S11  : S0;
      S1:    n = x ? S11  : S0;
      S11:   n = x ? S11  : S110;
      S110:  n = x ? S1   : S00;
      default: n = START;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/seq_det_core.sv
// rtl/seq_det_core.sv - serial 001/110 sequence detector, one bit per adv
// Ports:
//   clk, rst  : clock, synchronous active-low reset (state -> START)
//   x         : serial input bit
//   adv       : consume x this cycle
//   clr       : force START on this edge; wins over adv
//   state     : current detector state encoding
//   hit       : combinational; adv is high and the next state is S001 or S110
module seq_det_core
  import pattern_scan_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       x,
  input  logic       adv,
  input  logic       clr,
  output logic [2:0] state,
  output logic       hit
);

  det_state_t cur;
  det_state_t nxt;

  assign nxt   = det_next(cur, x);
  assign state = cur;
  assign hit   = adv && !clr && ((nxt == S001) || (nxt == S110));

  always_ff @(posedge clk) begin
    if (!rst) begin
      cur <= START;
    end else if (clr) begin
      cur <= START;
    end else if (adv) begin
      cur <= nxt;
    end
  end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// rtl/pattern_scan_ctrl.sv - word-level controller feeding the serial detector MSB-first
// Ports:
//   clk, rst            : clock, synchronous active-low reset
//   in_valid/in_ready   : input word handshake
//   in_data, in_cont    : word (MSB shifted first); 1 = continue detector state
//   out_valid/out_ready : result handshake
//   out_map, out_count  : per-bit match map and its popcount
//   busy                : controller not in IDLE
module pattern_scan_ctrl
  import pattern_scan_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_cont,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_map,
  output logic [CW-1:0]    out_count,
  output logic             busy
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  ctrl_state_t      state;
  ctrl_state_t      state_nxt;
  logic [WIDTH-1:0] data;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] map;
  logic [CW-1:0]    count;
  logic             accept;
  logic             det_adv;
  logic             det_clr;
  logic             det_hit;
  logic [2:0]       det_state;

  seq_det_core u_det (
    .clk   (clk),
    .rst   (rst),
    .x     (data[idx]),
    .adv   (det_adv),
    .clr   (det_clr),
    .state (det_state),
    .hit   (det_hit)
  );

  // 3'b111 is not a detector encoding.
  always_comb begin
    assert (det_state != 3'b111);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (idx == '0) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic; in_ready is masked by rst so it is low throughout reset.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    det_adv   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = rst;
        busy     = 1'b0;
      end
      SHIFT:   det_adv   = 1'b1;
      DONE:    out_valid = 1'b1;
      default: busy      = 1'b1;
    endcase
  end

  assign accept  = in_valid && in_ready;
  // Restart happens on the accepting edge itself, so in_cont needs no register.
  assign det_clr = accept && !in_cont;

  // Datapath: word, bit index, match map and count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      data  <= '0;
      idx   <= '0;
      map   <= '0;
      count <= '0;
    end else if (accept) begin
      data  <= in_data;
      idx   <= IW'(WIDTH - 1);
      map   <= '0;
      count <= '0;
    end else if (state == SHIFT) begin
      if (det_hit) begin
        map[idx] <= 1'b1;
        count    <= count + CW'(1);
      end
      idx <= idx - IW'(1);
    end
  end

  assign out_map   = map;
  assign out_count = count;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// tb/tb_pattern_scan_ctrl.sv - directed table-driven bench for pattern_scan_ctrl
module tb_pattern_scan_ctrl;

  localparam int WIDTH = 8;
  localparam int CW    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_cont;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_map;
  logic [CW-1:0]    out_count;
  logic             busy;

  pattern_scan_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_cont   (in_cont),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_map   (out_map),
    .out_count (out_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             cont;
    logic [WIDTH-1:0] exp_map;
    logic [CW-1:0]    exp_count;
  } vec_t;

  vec_t vecs[10];
  vec_t tp[4];

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_word(input string name, input vec_t v);
    int cyc;
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      step();
      cyc++;
    end
    chk({name, " ready"}, in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = v.data;
    in_cont  = v.cont;
    step();
    in_valid = 1'b0;
    in_data  = 8'hA5;
    in_cont  = 1'b0;
    chk({name, " busy"}, busy, 1'b1);
    cyc = 0;
    while (!out_valid && cyc < 30) begin
      step();
      cyc++;
    end
    chk({name, " latency"}, cyc, WIDTH);
    chk({name, " map"}, out_map, v.exp_map);
    chk({name, " count"}, out_count, v.exp_count);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({name, " idle after"}, in_ready, 1'b1);
  endtask

  initial begin
    int cyc;
    int acc_n;
    int res_n;
    int last_acc;
    vec_t v;

    vecs[0] = '{8'b0010_0000, 1'b0, 8'b0010_0000, 4'd1};
    vecs[1] = '{8'b1101_1000, 1'b0, 8'b0010_0100, 4'd2};
    vecs[2] = '{8'h00,        1'b0, 8'h00,        4'd0};
    vecs[3] = '{8'h80,        1'b1, 8'h80,        4'd1};
    vecs[4] = '{8'h80,        1'b0, 8'h00,        4'd0};
    vecs[5] = '{8'hFF,        1'b0, 8'h00,        4'd0};
    vecs[6] = '{8'b1100_1100, 1'b0, 8'b0010_1010, 4'd3};
    vecs[7] = '{8'h01,        1'b1, 8'h01,        4'd1};
    vecs[8] = '{8'h40,        1'b1, 8'h00,        4'd0};
    vecs[9] = '{8'h80,        1'b1, 8'h80,        4'd1};

    tp[0] = '{8'b0010_0000, 1'b0, 8'b0010_0000, 4'd1};
    tp[1] = '{8'b1101_1000, 1'b0, 8'b0010_0100, 4'd2};
    tp[2] = '{8'b1100_1100, 1'b0, 8'b0010_1010, 4'd3};
    tp[3] = '{8'h01,        1'b1, 8'h01,        4'd1};

    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_cont = 1'b0; out_ready = 1'b0;
    step();
    step();
    chk("rst in_ready", in_ready, 1'b0);
    chk("rst out_valid", out_valid, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst map", out_map, 8'h00);
    chk("rst count", out_count, 4'd0);
    rst = 1'b1;
    #1;
    chk("release in_ready", in_ready, 1'b1);
    step();

    for (int i = 0; i < 10; i++) begin
      run_word($sformatf("vec%0d", i), vecs[i]);
    end

    // Stall in DONE with in_valid pulsing.
    v = '{8'b1101_1000, 1'b0, 8'b0010_0100, 4'd2};
    in_valid = 1'b1; in_data = v.data; in_cont = 1'b0;
    step();
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 30) begin
      step();
      cyc++;
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_data  = 8'h20;
      step();
      chk($sformatf("stall%0d valid", i), out_valid, 1'b1);
      chk($sformatf("stall%0d map", i), out_map, v.exp_map);
      chk($sformatf("stall%0d count", i), out_count, v.exp_count);
      chk($sformatf("stall%0d in_ready", i), in_ready, 1'b0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("stall no accept", busy, 1'b0);

    // Reset after three SHIFT cycles.
    in_valid = 1'b1; in_data = 8'hFF; in_cont = 1'b0;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("abort busy", busy, 1'b0);
    chk("abort in_ready", in_ready, 1'b1);
    chk("abort out_valid", out_valid, 1'b0);
    chk("abort det START", dut.det_state, 3'b001);
    step();
    run_word("after abort", '{8'b0010_0000, 1'b1, 8'b0010_0000, 4'd1});

    // Throughput with both handshakes held high.
    acc_n = 0; res_n = 0; last_acc = 0; cyc = 0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = tp[0].data; in_cont = tp[0].cont;
    while ((acc_n < 4 || res_n < 4) && cyc < 100) begin
      if (out_valid && out_ready && res_n < 4) begin
        chk($sformatf("tp%0d map", res_n), out_map, tp[res_n].exp_map);
        chk($sformatf("tp%0d count", res_n), out_count, tp[res_n].exp_count);
        res_n++;
      end
      if (in_valid && in_ready) begin
        if (acc_n > 0) chk($sformatf("tp%0d spacing", acc_n), cyc - last_acc, 10);
        last_acc = cyc;
        acc_n++;
      end
      step();
      cyc++;
      if (acc_n < 4) begin
        in_data = tp[acc_n].data;
        in_cont = tp[acc_n].cont;
      end else begin
        in_valid = 1'b0;
      end
    end
    chk("tp accepted", acc_n, 4);
    chk("tp results", res_n, 4);
    out_ready = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
